// File: rtl/peri_leds.sv
// LED output peripheral: control register (pattern/blink/rate/dim) plus a hardware blink engine.
// Optional PWM dimming is enabled by defining PERI_LEDS_PWM_EN.
module peri_leds #(
  parameter int BASE_CYCLES = 156_250,
  parameter int NUM_LEDS    = 16
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                we_i,
  input  logic [31:0]         data_i,
  output logic [31:0]         data_o,
  output logic [NUM_LEDS-1:0] leds_o
);

  localparam int CW = $clog2(BASE_CYCLES * 128);
  localparam logic [CW-1:0] BASE_W = CW'(BASE_CYCLES);

`ifdef PERI_LEDS_PWM_EN
  localparam logic [31:0] WMASK = 32'h00FF_FFFF;
`else
  localparam logic [31:0] WMASK = 32'h000F_FFFF;
`endif

  logic [31:0]         ctrl;
  logic [CW-1:0]       blink_cnt;
  logic [CW-1:0]       half_m1;
  logic                phase;
  logic                blink_en;
  logic                tc;
  logic                pwm_on;
  logic [2:0]          rate;
  logic [NUM_LEDS-1:0] pattern;

  assign data_o   = ctrl;
  assign pattern  = ctrl[NUM_LEDS-1:0];
  assign blink_en = ctrl[16];
  assign rate     = ctrl[19:17];

  // Modular CW-bit arithmetic keeps the terminal count correct even when
  // BASE_CYCLES<<7 lands exactly on 2**CW.
  always_comb begin
    half_m1 = (BASE_W << rate) - CW'(1);
    tc      = blink_en && (blink_cnt == half_m1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ctrl      <= '0;
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (we_i) begin
      ctrl      <= data_i & WMASK;
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (!blink_en) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (tc) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + CW'(1);
    end
  end

`ifdef PERI_LEDS_PWM_EN
  logic [3:0] pwm_cnt;

  always_ff @(posedge clk_i) begin
    if (reset_i) pwm_cnt <= '0;
    else         pwm_cnt <= pwm_cnt + 4'd1;
  end

  assign pwm_on = (pwm_cnt >= ctrl[23:20]);
`else
  assign pwm_on = 1'b1;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) leds_o <= '0;
    else         leds_o <= pattern & {NUM_LEDS{phase}} & {NUM_LEDS{pwm_on}};
  end

endmodule
